// File: rtl/event_dispatcher_pkg.sv
// event_dispatcher_pkg
//   Shared definitions for the event dispatcher and the per-region queue side:
//   the sensor event record, default sensor geometry and region grid, index
//   widths, and a constant function that builds the region boundary table.
//   No ports (package).
package event_dispatcher_pkg;

    localparam int XY_BITS = 12;
    localparam int TS_BITS = 16;

    localparam int DEFAULT_SENSOR_WIDTH  = 640;
    localparam int DEFAULT_SENSOR_HEIGHT = 480;
    localparam int DEFAULT_X_DIVISIONS   = 2;
    localparam int DEFAULT_Y_DIVISIONS   = 2;

    // Upper bound on divisions per axis; sizes the boundary table.
    localparam int MAX_DIVISIONS = 16;

    // Index width for n choices; a single choice still needs one bit.
    function automatic int div_bits(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int X_DIV_BITS = div_bits(DEFAULT_X_DIVISIONS);
    localparam int Y_DIV_BITS = div_bits(DEFAULT_Y_DIVISIONS);

    typedef struct packed {
        logic [TS_BITS-1:0] ts;
        logic               polarity;
        logic [XY_BITS-1:0] y;
        logic [XY_BITS-1:0] x;
    } event_t;

    typedef logic [MAX_DIVISIONS-1:0][XY_BITS-1:0] bounds_t;

    // Entry i is the first coordinate of region i along one axis.
    function automatic bounds_t region_bounds(input int extent, input int divisions);
        bounds_t b;
        b = '0;
        for (int i = 0; i < MAX_DIVISIONS; i++) begin
            if (i < divisions) begin
                b[i] = XY_BITS'(i * (extent / divisions));
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/event_dispatcher_region_lookup.sv
// event_dispatcher_region_lookup
//   Purely combinational mapping of an event's (x,y) to its region.
//   Ports:
//     evt     in   event to classify (only x, y are examined)
//     x_dest  out  column index, clamped to the last column
//     y_dest  out  row index, clamped to the last row
//     dest    out  flattened destination y_dest*X_DIVISIONS + x_dest
module event_dispatcher_region_lookup
    import event_dispatcher_pkg::*;
#(
    parameter int X_DIVISIONS   = DEFAULT_X_DIVISIONS,
    parameter int Y_DIVISIONS   = DEFAULT_Y_DIVISIONS,
    parameter int SENSOR_WIDTH  = DEFAULT_SENSOR_WIDTH,
    parameter int SENSOR_HEIGHT = DEFAULT_SENSOR_HEIGHT,
    localparam int XD_BITS   = div_bits(X_DIVISIONS),
    localparam int YD_BITS   = div_bits(Y_DIVISIONS),
    localparam int DEST_BITS = div_bits(X_DIVISIONS * Y_DIVISIONS)
) (
    input  event_t               evt,
    output logic [XD_BITS-1:0]   x_dest,
    output logic [YD_BITS-1:0]   y_dest,
    output logic [DEST_BITS-1:0] dest
);

    localparam bounds_t X_BOUNDS = region_bounds(SENSOR_WIDTH, X_DIVISIONS);
    localparam bounds_t Y_BOUNDS = region_bounds(SENSOR_HEIGHT, Y_DIVISIONS);

    // Scanning only up to DIVISIONS-1 gives the clamp for free: anything
    // past the last boundary, including off-sensor coordinates, stays there.
    always_comb begin
        x_dest = '0;
        for (int i = 1; i < X_DIVISIONS; i++) begin
            if (evt.x >= X_BOUNDS[i]) x_dest = XD_BITS'(i);
        end
        y_dest = '0;
        for (int j = 1; j < Y_DIVISIONS; j++) begin
            if (evt.y >= Y_BOUNDS[j]) y_dest = YD_BITS'(j);
        end
    end

    assign dest = DEST_BITS'(y_dest) * DEST_BITS'(X_DIVISIONS) + DEST_BITS'(x_dest);

    // Timestamp and polarity do not affect routing.
    logic unused_evt_bits;
    assign unused_evt_bits = ^{evt.ts, evt.polarity};

endmodule

// File: rtl/event_dispatcher.sv
// event_dispatcher
//   Routes a single sensor event stream to X_DIVISIONS*Y_DIVISIONS region
//   queues through a two-register pipeline (route register A, output
//   register B). An entry blocked at B for STALL_LIMIT cycles is dropped.
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     in_valid/ready  input handshake, in_event carries the event
//     out_valid       one-hot, bit d offers out_event to queue d
//     out_ready       per-queue ready; only the addressed bit matters
//     out_event       shared output event bus
//     stall_pulse     one-cycle pulse the cycle after an entry is dropped
//     accepted_count  saturating count of input handshakes
//     drop_count      saturating count of dropped entries
//     fsm_state       output-register state (0 empty, 1 holding)
//
//   Handshake rule (both sides): a transfer happens in a cycle where valid
//   and ready are both high at the rising edge; valid, once raised, holds
//   its data until that transfer. in_ready may depend combinationally on
//   out_ready.
module event_dispatcher
    import event_dispatcher_pkg::*;
#(
    parameter int X_DIVISIONS   = DEFAULT_X_DIVISIONS,
    parameter int Y_DIVISIONS   = DEFAULT_Y_DIVISIONS,
    parameter int SENSOR_WIDTH  = DEFAULT_SENSOR_WIDTH,
    parameter int SENSOR_HEIGHT = DEFAULT_SENSOR_HEIGHT,
    parameter int STALL_LIMIT   = 64,
    parameter int CNT_BITS      = 16,
    localparam int NUM_DEST     = X_DIVISIONS * Y_DIVISIONS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  event_t              in_event,
    output logic [NUM_DEST-1:0] out_valid,
    input  logic [NUM_DEST-1:0] out_ready,
    output event_t              out_event,
    output logic                stall_pulse,
    output logic [CNT_BITS-1:0] accepted_count,
    output logic [CNT_BITS-1:0] drop_count,
    output logic [0:0]          fsm_state
);

    localparam int XD_BITS   = div_bits(X_DIVISIONS);
    localparam int YD_BITS   = div_bits(Y_DIVISIONS);
    localparam int DEST_BITS = div_bits(NUM_DEST);
    localparam int WAIT_BITS = (STALL_LIMIT < 2) ? 1 : $clog2(STALL_LIMIT);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    // Stage A
    logic                 live;
    logic                 a_valid;
    event_t               a_event;
    logic [DEST_BITS-1:0] a_dest;
    logic [XD_BITS-1:0]   a_x_dest;
    logic [YD_BITS-1:0]   a_y_dest;

    // Stage B
    logic [0:0]           b_state;
    event_t               b_event;
    logic [DEST_BITS-1:0] b_dest;
    logic [WAIT_BITS-1:0] wait_cnt;

    logic b_hold;
    logic b_ready;
    logic b_done;
    logic b_drop;
    logic b_free;
    logic a_advance;
    logic in_fire;

    event_dispatcher_region_lookup #(
        .X_DIVISIONS  (X_DIVISIONS),
        .Y_DIVISIONS  (Y_DIVISIONS),
        .SENSOR_WIDTH (SENSOR_WIDTH),
        .SENSOR_HEIGHT(SENSOR_HEIGHT)
    ) u_lookup (
        .evt   (a_event),
        .x_dest(a_x_dest),
        .y_dest(a_y_dest),
        .dest  (a_dest)
    );

    // Per-axis indices are for the queue side; routing needs only dest.
    logic unused_axis_dest;
    assign unused_axis_dest = ^{a_x_dest, a_y_dest};

    assign b_hold = (b_state == ST_HOLD);

    always_comb begin
        out_valid = '0;
        if (b_hold) out_valid[b_dest] = 1'b1;
    end

    // Masking with out_valid ignores ready bits of other queues.
    assign b_ready = |(out_valid & out_ready);
    assign b_done  = b_hold && b_ready;

    generate
        if (STALL_LIMIT != 0) begin : g_drop
            assign b_drop = b_hold && !b_ready &&
                            (wait_cnt == WAIT_BITS'(STALL_LIMIT - 1));
        end else begin : g_no_drop
            assign b_drop = 1'b0;
        end
    endgenerate

    // B frees its slot on completion or drop, so A can move up in the same
    // cycle and the pipe sustains one event per cycle.
    assign b_free    = !b_hold || b_done || b_drop;
    assign a_advance = a_valid && b_free;
    // live keeps in_ready low while reset is asserted and on the first edge.
    assign in_ready  = live && (!a_valid || a_advance);
    assign in_fire   = in_valid && in_ready;

    assign out_event = b_event;
    assign fsm_state = b_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live           <= 1'b0;
            a_valid        <= 1'b0;
            a_event        <= '0;
            b_state        <= ST_EMPTY;
            b_event        <= '0;
            b_dest         <= '0;
            wait_cnt       <= '0;
            stall_pulse    <= 1'b0;
            accepted_count <= '0;
            drop_count     <= '0;
        end else begin
            live <= 1'b1;

            if (in_fire) begin
                a_valid <= 1'b1;
                a_event <= in_event;
            end else if (a_advance) begin
                a_valid <= 1'b0;
            end

            if (b_free) begin
                if (a_valid) begin
                    b_state  <= ST_HOLD;
                    b_event  <= a_event;
                    b_dest   <= a_dest;
                    wait_cnt <= '0;
                end else begin
                    b_state <= ST_EMPTY;
                end
            end else begin
                // Not free implies holding with the addressed ready low.
                wait_cnt <= wait_cnt + WAIT_BITS'(1);
            end

            stall_pulse <= b_drop;

            if (in_fire && (accepted_count != CNT_MAX)) begin
                accepted_count <= accepted_count + CNT_BITS'(1);
            end
            if (b_drop && (drop_count != CNT_MAX)) begin
                drop_count <= drop_count + CNT_BITS'(1);
            end
        end
    end

endmodule

// File: tb/tb_event_dispatcher.sv
`timescale 1ns/1ps
// tb_event_dispatcher
//   Two dispatcher instances: k=0 with STALL_LIMIT=64/CNT_BITS=16, k=1 with
//   STALL_LIMIT=4/CNT_BITS=4. A queue-based model of each is checked every
//   negedge; directed tests pin latency, routing, backpressure, timeout,
//   reset and saturation with literal expectations.
module tb_event_dispatcher;
    import event_dispatcher_pkg::*;

    localparam int ND = 4;
    localparam int SW = 640;
    localparam int SH = 480;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          in_valid_v  [2];
    event_t        in_event_v  [2];
    logic [ND-1:0] out_ready_v [2];
    logic          in_ready_v  [2];
    logic [ND-1:0] out_valid_v [2];
    event_t        out_event_v [2];
    logic          stall_v     [2];
    logic [15:0]   acc_v       [2];
    logic [15:0]   drop_v      [2];
    logic [0:0]    state_v     [2];
    logic [3:0]    acc_small;
    logic [3:0]    drop_small;

    assign acc_v[1]  = {12'd0, acc_small};
    assign drop_v[1] = {12'd0, drop_small};

    event_dispatcher #(.STALL_LIMIT(64), .CNT_BITS(16)) dut_main (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[0]), .in_ready(in_ready_v[0]), .in_event(in_event_v[0]),
        .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_event(out_event_v[0]),
        .stall_pulse(stall_v[0]), .accepted_count(acc_v[0]), .drop_count(drop_v[0]),
        .fsm_state(state_v[0])
    );

    event_dispatcher #(.STALL_LIMIT(4), .CNT_BITS(4)) dut_small (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_v[1]), .in_ready(in_ready_v[1]), .in_event(in_event_v[1]),
        .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_event(out_event_v[1]),
        .stall_pulse(stall_v[1]), .accepted_count(acc_small), .drop_count(drop_small),
        .fsm_state(state_v[1])
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    event_t exp_q0[$];
    event_t exp_q1[$];
    int     acc_m  [2];
    int     drop_m [2];
    int     wait_m [2];
    logic   pulse_exp [2];

    function automatic int lim(input int k);
        return (k == 0) ? 64 : 4;
    endfunction

    function automatic int cmax(input int k);
        return (k == 0) ? 65535 : 15;
    endfunction

    function automatic int dest_of(input event_t e);
        int xd;
        int yd;
        xd = int'(e.x) / (SW / 2);
        if (xd > 1) xd = 1;
        yd = int'(e.y) / (SH / 2);
        if (yd > 1) yd = 1;
        return yd * 2 + xd;
    endfunction

    task automatic model_pop(input int k);
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
    endtask

    task automatic model_reset(input int k);
        if (k == 0) exp_q0.delete();
        else        exp_q1.delete();
        acc_m[k] = 0;
        drop_m[k] = 0;
        wait_m[k] = 0;
        pulse_exp[k] = 1'b0;
    endtask

    task automatic compare_cycle(input int k);
        int            qn;
        event_t        head;
        logic [ND-1:0] exp_ov;
        qn = (k == 0) ? exp_q0.size() : exp_q1.size();
        check("stall_pulse", stall_v[k], pulse_exp[k]);
        check("accepted_count", acc_v[k], acc_m[k]);
        check("drop_count", drop_v[k], drop_m[k]);
        pulse_exp[k] = 1'b0;
        if (qn == 0) begin
            check("out_valid_idle", out_valid_v[k], 0);
            wait_m[k] = 0;
        end else if (out_valid_v[k] != 0) begin
            head = (k == 0) ? exp_q0[0] : exp_q1[0];
            exp_ov = ND'(1) << dest_of(head);
            check("out_valid_route", out_valid_v[k], exp_ov);
            check("out_event_order", out_event_v[k], head);
            if ((out_valid_v[k] & out_ready_v[k]) != 0) begin
                model_pop(k);
                wait_m[k] = 0;
            end else begin
                wait_m[k]++;
                if (wait_m[k] == lim(k)) begin
                    model_pop(k);
                    wait_m[k] = 0;
                    if (drop_m[k] < cmax(k)) drop_m[k]++;
                    pulse_exp[k] = 1'b1;
                end
            end
        end else begin
            wait_m[k] = 0;
        end
        if (in_valid_v[k] && in_ready_v[k]) begin
            if (k == 0) exp_q0.push_back(in_event_v[k]);
            else        exp_q1.push_back(in_event_v[k]);
            if (acc_m[k] < cmax(k)) acc_m[k]++;
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                check("rst_out_valid", out_valid_v[k], 0);
                check("rst_in_ready", in_ready_v[k], 0);
                check("rst_stall", stall_v[k], 0);
                check("rst_acc", acc_v[k], 0);
                check("rst_drop", drop_v[k], 0);
                model_reset(k);
            end else begin
                compare_cycle(k);
            end
        end
    end

    // ---------------- drivers ----------------
    event_t        ev_tbl   [32];
    logic [ND-1:0] ov_log   [64];
    logic          rdy_log  [64];
    logic          hs_log   [64];
    logic          dl_log   [64];
    logic          pulse_log[64];

    function automatic event_t mk(input int x, input int y, input int ts);
        event_t e;
        e.x = XY_BITS'(x);
        e.y = XY_BITS'(y);
        e.ts = TS_BITS'(ts);
        e.polarity = ts[0];
        return e;
    endfunction

    task automatic idle_all();
        for (int k = 0; k < 2; k++) begin
            in_valid_v[k] = 1'b0;
            in_event_v[k] = '0;
            out_ready_v[k] = '1;
        end
    endtask

    // Entered and left at posedge+1.
    task automatic do_reset();
        idle_all();
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Offers ev_tbl[0..n-1] in order on instance k for ncyc cycles; ready
    // bits in low_mask are held low for the first low_cycles cycles.
    task automatic run_stream(input int k, input int n, input int ncyc,
                              input logic [ND-1:0] low_mask, input int low_cycles);
        int sent;
        sent = 0;
        for (int c = 0; c < ncyc; c++) begin
            in_valid_v[k] = (sent < n);
            in_event_v[k] = ev_tbl[(sent < n) ? sent : 0];
            out_ready_v[k] = (c < low_cycles) ? ~low_mask : '1;
            @(negedge clk);
            ov_log[c]    = out_valid_v[k];
            rdy_log[c]   = in_ready_v[k];
            pulse_log[c] = stall_v[k];
            hs_log[c]    = in_valid_v[k] && in_ready_v[k];
            dl_log[c]    = (out_valid_v[k] & out_ready_v[k]) != 0;
            if (hs_log[c]) sent++;
            @(posedge clk);
            #1;
        end
        in_valid_v[k] = 1'b0;
        out_ready_v[k] = '1;
        check("all_sent", sent, n);
    endtask

    initial begin
        int cnt;
        int first;
        idle_all();
        @(posedge clk);
        #1;
        do_reset();

        // 1: routing and latency, always ready
        ev_tbl[0] = mk(319, 0, 1);
        ev_tbl[1] = mk(320, 0, 2);
        ev_tbl[2] = mk(0, 240, 3);
        ev_tbl[3] = mk(639, 479, 4);
        run_stream(0, 4, 8, '0, 0);
        for (int i = 0; i < 4; i++) check("t1_accept", hs_log[i], 1);
        check("t1_ov_c1", ov_log[1], 4'b0000);
        check("t1_ov_c2", ov_log[2], 4'b0001);
        check("t1_ov_c3", ov_log[3], 4'b0010);
        check("t1_ov_c4", ov_log[4], 4'b0100);
        check("t1_ov_c5", ov_log[5], 4'b1000);
        check("t1_ov_c6", ov_log[6], 4'b0000);
        check("t1_acc", acc_v[0], 4);

        // 2: out-of-range lands in the last region
        do_reset();
        ev_tbl[0] = mk(700, 500, 5);
        run_stream(0, 1, 5, '0, 0);
        check("t2_ov_c2", ov_log[2], 4'b1000);
        check("t2_drop", drop_v[0], 0);

        // 3: backpressure on queue 1 for 10 cycles
        do_reset();
        for (int i = 0; i < 5; i++) ev_tbl[i] = mk(400 + i * 10, 20 + i, 10 + i);
        run_stream(0, 5, 30, 4'b0010, 10);
        cnt = 0;
        for (int c = 0; c < 10; c++) cnt += int'(hs_log[c]);
        check("t3_accepted_while_blocked", cnt, 2);
        check("t3_in_ready_c9", rdy_log[9], 0);
        check("t3_held_c9", ov_log[9], 4'b0010);
        check("t3_first_delivery_c10", dl_log[10], 1);
        cnt = 0;
        for (int c = 0; c < 30; c++) cnt += int'(dl_log[c]);
        check("t3_delivered", cnt, 5);
        check("t3_drop", drop_v[0], 0);
        check("t3_acc", acc_v[0], 5);

        // 4: timeout with STALL_LIMIT=4
        do_reset();
        ev_tbl[0] = mk(0, 300, 20);
        ev_tbl[1] = mk(10, 10, 21);
        run_stream(1, 2, 12, 4'b0100, 12);
        cnt = 0;
        for (int c = 0; c < 12; c++) cnt += int'(pulse_log[c]);
        check("t4_pulse_count", cnt, 1);
        check("t4_pulse_c6", pulse_log[6], 1);
        check("t4_held_c5", ov_log[5], 4'b0100);
        check("t4_next_c6", ov_log[6], 4'b0001);
        check("t4_next_delivered_c6", dl_log[6], 1);
        check("t4_drop", drop_v[1], 1);

        // 5: asynchronous reset while B holds
        do_reset();
        ev_tbl[0] = mk(400, 0, 30);
        run_stream(0, 1, 4, 4'b0010, 4);
        out_ready_v[0] = 4'b1101;
        #1;
        check("t5_hold_before", state_v[0], 1);
        check("t5_ov_before", out_valid_v[0], 4'b0010);
        rst_n = 1'b0;
        #1;
        check("t5_ov_in_reset", out_valid_v[0], 0);
        check("t5_acc_in_reset", acc_v[0], 0);
        check("t5_state_in_reset", state_v[0], 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        out_ready_v[0] = '1;
        @(posedge clk);
        #1;
        ev_tbl[0] = mk(10, 300, 31);
        run_stream(0, 1, 6, '0, 0);
        first = -1;
        for (int c = 0; c < 4; c++) if (hs_log[c] && first < 0) first = c;
        check("t5_accept_c0", first, 0);
        check("t5_ov_lat1", ov_log[1], 4'b0000);
        check("t5_ov_lat2", ov_log[2], 4'b0100);
        check("t5_pulse_none", pulse_log[2], 0);

        // 6: 4-bit counter saturation
        do_reset();
        for (int i = 0; i < 20; i++) ev_tbl[i] = mk(i * 30, i * 20, 40 + i);
        run_stream(1, 20, 26, '0, 0);
        check("t6_acc_sat", acc_v[1], 15);
        check("t6_drop", drop_v[1], 0);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_dispatcher.md
Name: event_dispatcher

Overview:
- Accepts the single sensor event stream over a valid/ready handshake and routes each event to one of X_DIVISIONS*Y_DIVISIONS destination queues by its (x,y) region.
- Sits between the sensor front end and the per-region event queues.
- Two-register pipeline, full throughput; a stall-timeout FSM drops an event whose destination stays blocked; saturating accept/drop counters.

Parameters:
- X_DIVISIONS, 2, number of horizontal regions (>=1)
- Y_DIVISIONS, 2, number of vertical regions (>=1)
- SENSOR_WIDTH, 640, pixels in x
- SENSOR_HEIGHT, 480, pixels in y
- STALL_LIMIT, 64, max cycles an output entry waits on its destination before it is dropped; 0 disables dropping
- CNT_BITS, 16, width of the statistics counters

Ports:
- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input event valid
- in_ready  out  1  dispatcher can accept an input event
- in_event  in  event_t  input event (fields x, y used for routing; all fields forwarded)
- out_valid  out  NUM_DEST  one-hot valid; bit d targets queue d, where NUM_DEST=X_DIVISIONS*Y_DIVISIONS
- out_ready  in  NUM_DEST  per-queue ready
- out_event  out  event_t  shared output event bus
- stall_pulse  out  1  one-cycle pulse when an event is dropped
- accepted_count  out  CNT_BITS  events accepted, saturating
- drop_count  out  CNT_BITS  events dropped, saturating

Behaviour:
- Reset (rst_n low, asynchronous): both stages empty, out_valid=0, out_event=0, stall_pulse=0, counters=0, wait counter=0.
- in_ready is 0 during reset.
- Stage A (route register):
  - Captures in_event when in_valid && in_ready.
  - region_lookup computes dest from the registered event combinationally.
- Region rule: x_dest = largest i with x >= i*(SENSOR_WIDTH/X_DIVISIONS), and x_dest is clamped to X_DIVISIONS-1. y_dest uses the same rule. dest = y_dest*X_DIVISIONS + x_dest.
- Out-of-range coordinates (x >= SENSOR_WIDTH) land in the last column/row.
- Stage B (output register) states: EMPTY, HOLD.
  - EMPTY: if A is valid, load B (event + dest) and go to HOLD.
  - HOLD: out_valid[dest]=1 and out_event=B.event.
  - If out_ready[dest]: handshake completes. Reload from A in the same cycle if A is valid (stay HOLD), else go to EMPTY.
  - Ready bits of other destinations are ignored.
  - If !out_ready[dest], the wait counter increments.
  - If STALL_LIMIT!=0 and the wait counter == STALL_LIMIT-1 with ready still low, the entry is dropped in that cycle. Dropping means: stall_pulse=1 next cycle, drop_count++, and B reloads from A or goes EMPTY as on a completed handshake.
  - The wait counter clears on every load or reload of B.
- A advances to B when B is EMPTY or B is completing/dropping this cycle.
- in_ready = !A_valid || A_advances. A combinational path from out_ready to in_ready is permitted.
- Latency: input handshake at cycle N → out_valid at N+2 when unstalled. Sustained 1 event/cycle when the destinations are ready.
- Ordering: strict FIFO across all destinations; a blocked destination head-of-line blocks all others until handshake or drop.
- accepted_count increments on each input handshake. Both counters saturate at 2^CNT_BITS-1 and do not wrap.
- Accept and drop in the same cycle update both counters independently.
- Reset mid-transfer discards both stages without a pulse.

Decomposition:
- Shared globals package: event_t, XY_BITS, SENSOR_WIDTH/HEIGHT, X/Y_DIVISIONS defaults, X_DIV_BITS/Y_DIV_BITS, and a constant function computing the region boundary array.
- Sub-module region_lookup: purely combinational, event_t in → x_dest, y_dest, flattened dest out. Reusable by the queue side.

Test Plan:
- 2x2 defaults, always ready: events (319,0),(320,0),(0,240),(639,479) on consecutive cycles → out_valid one-hot 0001,0010,0100,1000 at cycles 2..5; accepted_count=4.
- Out of range: event (700,500) → routed to dest 3, no drop.
- Backpressure: out_ready[1]=0 for 10 cycles with STALL_LIMIT=64, stream of 5 events to dest 1 → in_ready falls after 2 accepted; after ready rises all 5 are delivered in order; drop_count=0.
- Timeout: out_ready[2] held 0, STALL_LIMIT=4, one event to dest 2 → stall_pulse exactly once (at 4 cycles of waiting after load, on the following cycle), drop_count=1, next queued event to dest 0 is delivered immediately after.
- Reset mid-operation: assert rst_n=0 asynchronously while B is in HOLD → out_valid=0 within the same cycle, counters=0; after release the first new event appears at latency 2.
- Saturation: CNT_BITS=4, 20 accepted events → accepted_count holds 15.
